truth_table_sweeper: RTL and testbench

Parametrised, clocked exhaustive stimulus engine for small combinational blocks.
- Walks every N_IN-bit input vector in a selectable order and holds each vector HOLD cycles.
- Samples the DUT output and builds the captured truth table.
- Compares the captured table against an expected table, counting mismatches.
- Sits between a bench or on-board controller and the combinational DUT, replacing hand-written counting stimulus.

---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/truth_table_sweeper_if.sv | 31 +++
 rtl/truth_table_sweeper_vec_map.sv | 22 ++
 rtl/truth_table_sweeper.sv | 121 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
//   MODE_*  : sweep order codes (2'b11 is reserved and behaves as MODE_UP)
//   state_t : controller states
package sweep_pkg;
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/data bundle between a sweep controller and the sweeper.
//   master : controller side (drives start/abort/mode/exp_tt and the DUT's q_in)
//   slave  : sweeper side (drives vec_out, status and results)
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int TT_W = 1 << N_IN;

    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [TT_W-1:0]   exp_tt;
    logic              q_in;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt_out;
    logic [N_IN:0]     err_count;
    logic              err_flag;
    logic [N_IN-1:0]   first_err_vec;

    modport master (
        output start, abort, mode, exp_tt, q_in,
        input  vec_out, busy, done, tt_out, err_count, err_flag, first_err_vec
    );

    modport slave (
        input  start, abort, mode, exp_tt, q_in,
        output vec_out, busy, done, tt_out, err_count, err_flag, first_err_vec
    );
endinterface

// File: rtl/truth_table_sweeper_vec_map.sv
// Combinational sweep-order map: (index, mode) -> vector.
//   index : position in the sweep, 0 .. 2^N_IN-1
//   mode  : sweep order code; reserved code falls back to ascending
//   vec   : vector value applied to the DUT for that position
module sweep_vec_map
    import sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] index,
    input  logic [1:0]      mode,
    output logic [N_IN-1:0] vec
);
    always_comb begin
        vec = index;
        case (mode)
            MODE_DOWN: vec = ~index;               // (2^N_IN-1) - index
            MODE_GRAY: vec = index ^ (index >> 1);
            default:   vec = index;
        endcase
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine for a small combinational DUT.
// Walks all 2^N_IN vectors in the latched order, holds each HOLD cycles,
// samples q_in on the last hold cycle, builds the captured truth table and
// counts mismatches against exp_tt.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : start/abort/mode/exp_tt/q_in in; vec_out, busy, done,
//                tt_out, err_count, err_flag, first_err_vec out
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int HOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.slave  bus
);
    localparam int              NVEC      = 1 << N_IN;
    localparam int              HW        = $clog2(HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN:0]   LAST_STEP = (N_IN + 1)'(NVEC - 1);

    state_t            state_q, state_d;
    logic [N_IN:0]     step_q;
    logic [HW-1:0]     hold_q;
    logic [1:0]        mode_q;
    logic [N_IN-1:0]   vec_q;
    logic [NVEC-1:0]   tt_q;
    logic [N_IN:0]     err_q;
    logic [N_IN-1:0]   first_q;
    logic              busy_q;
    logic              done_q;

    logic              start_ok;
    logic              sample;
    logic              last;
    logic              mismatch;
    logic [N_IN-1:0]   map_idx;
    logic [1:0]        map_mode;
    logic [N_IN-1:0]   map_vec;

    assign start_ok = (state_q == IDLE) && bus.start && !bus.abort;
    // abort suppresses the sample that would otherwise land on the same edge
    assign sample   = (state_q == RUN) && !bus.abort && (hold_q == HOLD_LAST);
    assign last     = sample && (step_q == LAST_STEP);
    assign mismatch = bus.q_in != bus.exp_tt[vec_q];

    // One mapper serves both the first vector (live mode) and every advance
    // (latched mode); the index wraps on the final step but is unused there.
    assign map_idx  = start_ok ? '0 : step_q[N_IN-1:0] + 1'b1;
    assign map_mode = start_ok ? bus.mode : mode_q;

    sweep_vec_map #(.N_IN(N_IN)) u_map (
        .index (map_idx),
        .mode  (map_mode),
        .vec   (map_vec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (bus.abort) state_d = IDLE;
                     else if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q  <= '0;
            hold_q  <= '0;
            mode_q  <= MODE_UP;
            vec_q   <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= last;
            if (start_ok) begin
                mode_q  <= bus.mode;
                step_q  <= '0;
                hold_q  <= '0;
                vec_q   <= map_vec;
                tt_q    <= '0;
                err_q   <= '0;
                first_q <= '0;
            end else if (state_q == RUN && !bus.abort) begin
                if (sample) begin
                    tt_q[vec_q] <= bus.q_in;
                    if (mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (err_q == '0) first_q <= vec_q;
                    end
                    step_q <= step_q + 1'b1;
                    hold_q <= '0;
                    if (!last) vec_q <= map_vec;  // last vector stays on the pins
                end else begin
                    hold_q <= hold_q + 1'b1;
                end
            end
        end
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.tt_out        = tt_q;
    assign bus.err_count     = err_q;
    assign bus.err_flag      = |err_q;
    assign bus.first_err_vec = first_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
    typedef struct {
        int          n;
        int          hold;
        int          mode;
        int          len;
        int          aborted;
        int          errc;
        int          first;
        logic [15:0] tt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [7:0]  dut3;
    logic [15:0] dut4;
    int checks = 0;
    int errors = 0;
    exp_t exp_q3[$];
    exp_t exp_q4[$];
    int seq3[$];
    int seq4[$];
    bit prev3, prev4, post3, post4;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(3)) bus3();
    truth_table_sweeper_if #(.N_IN(4)) bus4();

    // Combinational DUTs under test: arbitrary truth tables.
    assign bus3.q_in = dut3[bus3.vec_out];
    assign bus4.q_in = dut4[bus4.vec_out];

    truth_table_sweeper #(.N_IN(3), .HOLD(2)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
    truth_table_sweeper #(.N_IN(4), .HOLD(1)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int ref_vec(input int n, input int mode, input int i);
        case (mode)
            1:       return ((1 << n) - 1) - i;
            2:       return i ^ (i >> 1);
            default: return i;
        endcase
    endfunction

    function automatic exp_t build(input int n, input int hold, input int mode,
                                   input logic [15:0] dut, input logic [15:0] expt, input int a);
        exp_t e;
        int k, v;
        bit found;
        k = (a != 0) ? (a - 1) / hold : (1 << n);
        e.n = n; e.hold = hold; e.mode = mode;
        e.len = (a != 0) ? a : (1 << n) * hold;
        e.aborted = (a != 0);
        e.tt = '0; e.errc = 0; e.first = 0; found = 0;
        for (int i = 0; i < k; i++) begin
            v = ref_vec(n, mode, i);
            e.tt[v] = dut[v];
            if (dut[v] != expt[v]) begin
                e.errc++;
                if (!found) begin e.first = v; found = 1; end
            end
        end
        return e;
    endfunction

    task automatic end_check(input int inst, input logic dn, input logic [15:0] tt, input int errc,
                             input logic ef, input int first, input int vlast, input int seq[$]);
        exp_t e;
        int mism;
        int sz;
        sz = (inst == 3) ? exp_q3.size() : exp_q4.size();
        chk("end_expected", sz != 0, 1);
        if (sz == 0) return;
        e = (inst == 3) ? exp_q3.pop_front() : exp_q4.pop_front();
        chk("end_kind_done", dn, e.aborted == 0);
        chk("tt_out", tt, e.tt);
        chk("err_count", errc, e.errc);
        chk("err_flag", ef, e.errc != 0);
        chk("first_err_vec", first, e.first);
        chk("busy_cycles", seq.size(), e.len);
        mism = 0;
        for (int j = 0; j < seq.size() && j < e.len; j++)
            if (seq[j] != ref_vec(e.n, e.mode, j / e.hold)) mism++;
        chk("vec_sequence", mism, 0);
        chk("vec_hold_last", vlast, ref_vec(e.n, e.mode, (e.len - 1) / e.hold));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev3 = 0; post3 = 0; seq3.delete();
        end else begin
            if (post3) begin chk("done_pulse3", bus3.done, 0); post3 = 0; end
            if (bus3.busy) seq3.push_back(int'(bus3.vec_out));
            else if (prev3) begin
                end_check(3, bus3.done, 16'(bus3.tt_out), int'(bus3.err_count), bus3.err_flag,
                          int'(bus3.first_err_vec), int'(bus3.vec_out), seq3);
                seq3.delete();
                post3 = bus3.done;
            end
            prev3 = bus3.busy;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev4 = 0; post4 = 0; seq4.delete();
        end else begin
            if (post4) begin chk("done_pulse4", bus4.done, 0); post4 = 0; end
            if (bus4.busy) seq4.push_back(int'(bus4.vec_out));
            else if (prev4) begin
                end_check(4, bus4.done, bus4.tt_out, int'(bus4.err_count), bus4.err_flag,
                          int'(bus4.first_err_vec), int'(bus4.vec_out), seq4);
                seq4.delete();
                post4 = bus4.done;
            end
            prev4 = bus4.busy;
        end
    end

    task automatic drive(input int inst, input bit s, input bit a, input logic [1:0] m);
        if (inst == 3) begin bus3.start = s; bus3.abort = a; bus3.mode = m; end
        else           begin bus4.start = s; bus4.abort = a; bus4.mode = m; end
    endtask

    // a = edge (relative to the start edge) at which abort is seen; 0 = full sweep.
    task automatic run_sweep(input int inst, input int mode, input logic [15:0] dut,
                             input logic [15:0] expt, input int a, input bit glitch_en);
        int hold, len, endn, gc, sz;
        logic bsy;
        hold = (inst == 3) ? 2 : 1;
        len  = (1 << inst) * hold;
        endn = (a != 0) ? a : len;
        gc = 0;
        if (glitch_en) begin
            if (a == 0)     gc = $urandom_range(len + 1, 1);
            else if (a > 1) gc = $urandom_range(a - 1, 1);
        end
        if (inst == 3) begin
            dut3 = dut[7:0]; bus3.exp_tt = expt[7:0];
            exp_q3.push_back(build(3, hold, mode, dut, expt, a));
        end else begin
            dut4 = dut; bus4.exp_tt = expt;
            exp_q4.push_back(build(4, hold, mode, dut, expt, a));
        end
        @(negedge clk);
        drive(inst, 1, 0, 2'(mode));
        @(negedge clk);
        drive(inst, 0, 0, 2'($urandom_range(3, 0)));
        for (int c = 1; c <= endn + 3; c++) begin
            drive(inst, c == gc, (a != 0) && (c == a), 2'($urandom_range(3, 0)));
            @(negedge clk);
        end
        drive(inst, 0, 0, 2'd0);
        sz  = (inst == 3) ? exp_q3.size() : exp_q4.size();
        bsy = (inst == 3) ? bus3.busy : bus4.busy;
        chk("end_seen", sz, 0);
        chk("idle_after", bsy, 0);
        if (inst == 3) exp_q3.delete(); else exp_q4.delete();
    endtask

    task automatic chk_zero3(input string tag);
        chk({tag, "_vec"},   bus3.vec_out, 0);
        chk({tag, "_busy"},  bus3.busy, 0);
        chk({tag, "_done"},  bus3.done, 0);
        chk({tag, "_tt"},    bus3.tt_out, 0);
        chk({tag, "_errc"},  bus3.err_count, 0);
        chk({tag, "_eflag"}, bus3.err_flag, 0);
        chk({tag, "_first"}, bus3.first_err_vec, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        dut3 = '0; dut4 = '0;
        drive(3, 0, 0, 2'd0); drive(4, 0, 0, 2'd0);
        bus3.exp_tt = '0; bus4.exp_tt = '0;
        #1;
        chk_zero3("reset");
        chk("reset4_busy", bus4.busy, 0);
        chk("reset4_tt", bus4.tt_out, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // AND gate in every order, then majority against flawed expectations
        run_sweep(3, 0, 16'h80, 16'h80, 0, 0);
        run_sweep(3, 2, 16'h80, 16'h80, 0, 0);
        run_sweep(3, 1, 16'h80, 16'h80, 0, 0);
        run_sweep(3, 3, 16'h80, 16'h80, 0, 0);
        run_sweep(3, 0, 16'hE8, 16'hC8, 0, 0);
        run_sweep(3, 0, 16'hE8, 16'h00, 0, 0);
        // abort seen on edge t0+7: three vectors sampled, then a clean full sweep
        run_sweep(3, 0, 16'h5B, 16'h00, 7, 0);
        run_sweep(3, 2, 16'hE8, 16'hE8, 0, 1);

        for (int r = 0; r < 12; r++) begin
            int a;
            a = ($urandom_range(2, 0) == 0) ? $urandom_range(15, 1) : 0;
            run_sweep(3, $urandom_range(3, 0), 16'($urandom_range(255, 0)),
                      16'($urandom_range(255, 0)), a, 1'($urandom_range(1, 0)));
        end

        run_sweep(4, 0, 16'h8000, 16'h8000, 0, 0);
        for (int r = 0; r < 6; r++) begin
            int a;
            a = ($urandom_range(2, 0) == 0) ? $urandom_range(15, 1) : 0;
            run_sweep(4, $urandom_range(3, 0), 16'($urandom), 16'($urandom), a,
                      1'($urandom_range(1, 0)));
        end

        // reset mid-sweep, off the clock edge
        dut3 = 8'hFF; bus3.exp_tt = 8'h00;
        @(negedge clk); drive(3, 1, 0, 2'd0);
        @(negedge clk); drive(3, 0, 0, 2'd0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero3("midreset");
        @(negedge clk);
        #2 reset = 1'b0;

        // start together with abort in IDLE must not launch a sweep
        @(negedge clk); drive(3, 1, 1, 2'd0);
        @(negedge clk); drive(3, 0, 0, 2'd0);
        repeat (3) @(negedge clk);
        chk("start_abort_busy", bus3.busy, 0);
        chk("start_abort_tt", bus3.tt_out, 0);

        run_sweep(3, 2, 16'h96, 16'h69, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
